// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word type, MIPS field bit positions and
// packed R-type / I-type views of the word.
package cpu_pkg;

  localparam int INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

endpackage

// File: rtl/instruction_reg_if.sv
// Fetch-side bus of the instruction register: capture request in, stored
// word and its pre-sliced fields out.
interface instruction_reg_if #(
  parameter int IW = 32
);
  logic          load_ir;
  logic [IW-1:0] instruction;
  logic [IW-1:0] instr_all;
  logic [4:0]    instr_25_21;
  logic [4:0]    instr_20_16;
  logic [15:0]   instr_15_0;
  logic [5:0]    instr_31_26;
  logic [4:0]    instr_15_11;
  logic [4:0]    instr_10_6;
  logic [5:0]    instr_5_0;
  logic          ir_valid;

  modport master (
    output load_ir, instruction,
    input  instr_all, instr_25_21, instr_20_16, instr_15_0,
           instr_31_26, instr_15_11, instr_10_6, instr_5_0, ir_valid
  );

  modport slave (
    input  load_ir, instruction,
    output instr_all, instr_25_21, instr_20_16, instr_15_0,
           instr_31_26, instr_15_11, instr_10_6, instr_5_0, ir_valid
  );
endinterface

// File: rtl/instr_fields.sv
// Purely combinational MIPS field slicer; shared with the decoder so both
// agree on the bit positions kept in cpu_pkg.
module instr_fields
  import cpu_pkg::*;
(
  input  instr_t      ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  rtype_t r_view;
  itype_t i_view;

  // R- and I-type share opcode/rs/rt, so rs/rt come from the R view and
  // only the immediate needs the I view.
  assign r_view = rtype_t'(ir);
  assign i_view = itype_t'(ir);

  assign opcode = r_view.opcode;
  assign rs     = r_view.rs;
  assign rt     = r_view.rt;
  assign rd     = r_view.rd;
  assign shamt  = r_view.shamt;
  assign funct  = r_view.funct;
  assign imm    = i_view.imm;

endmodule

// File: rtl/instruction_reg.sv
// Multicycle-CPU instruction register: captures the fetched word on load_ir
// and presents it whole and as decoded MIPS fields until the next load.
module instruction_reg
  import cpu_pkg::*;
#(
  parameter int          IW      = 32,
  parameter logic [IW-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             reset,
  instruction_reg_if.slave bus
);

  // Field positions are only meaningful for the 32-bit MIPS encoding.
  if (IW != INSTR_W) begin : g_iw_check
    $error("instruction_reg: IW must be 32");
  end

  logic [IW-1:0] ir_q;
  logic          valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= RST_VAL;
      valid_q <= 1'b0;
    end else if (bus.load_ir) begin
      ir_q    <= bus.instruction;
      valid_q <= 1'b1;
    end
  end

  assign bus.instr_all = ir_q;
  assign bus.ir_valid  = valid_q;

  instr_fields u_fields (
    .ir     (ir_q),
    .opcode (bus.instr_31_26),
    .rs     (bus.instr_25_21),
    .rt     (bus.instr_20_16),
    .rd     (bus.instr_15_11),
    .shamt  (bus.instr_10_6),
    .funct  (bus.instr_5_0),
    .imm    (bus.instr_15_0)
  );

endmodule

// File: tb/tb_instruction_reg.sv
// Bench for instruction_reg: directed vector table, a no-bypass sequence and
// a randomized sweep against a behavioural model of the capture rules.
module tb_instruction_reg;

  logic clk = 1'b0;
  logic reset;

  instruction_reg_if #(.IW(32)) bus ();

  instruction_reg #(.IW(32), .RST_VAL(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        load;
    logic [31:0] instr;
    logic [31:0] exp_all;
    logic        exp_valid;
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected fields are derived arithmetically from the expected whole word.
  task automatic check_all(input string tag, input logic [31:0] w, input logic v);
    cmp({tag, " all"},   bus.instr_all, w);
    cmp({tag, " 25_21"}, 32'(bus.instr_25_21), (w / 32'd2097152) % 32'd32);
    cmp({tag, " 20_16"}, 32'(bus.instr_20_16), (w / 32'd65536) % 32'd32);
    cmp({tag, " 15_0"},  32'(bus.instr_15_0),  w % 32'd65536);
    cmp({tag, " 31_26"}, 32'(bus.instr_31_26), w / 32'd67108864);
    cmp({tag, " 15_11"}, 32'(bus.instr_15_11), (w / 32'd2048) % 32'd32);
    cmp({tag, " 10_6"},  32'(bus.instr_10_6),  (w / 32'd64) % 32'd32);
    cmp({tag, " 5_0"},   32'(bus.instr_5_0),   w % 32'd64);
    cmp({tag, " valid"}, 32'(bus.ir_valid),    32'(v));
  endtask

  task automatic drive(input logic r, input logic l, input logic [31:0] w);
    @(negedge clk);
    reset           = r;
    bus.load_ir     = l;
    bus.instruction = w;
  endtask

  vec_t vecs[11];
  logic [31:0] m_word;
  logic        m_valid;

  initial begin
    reset = 1'b1; bus.load_ir = 1'b0; bus.instruction = '0;

    vecs[0]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h5FF7_9ABF, 32'h5FF7_9ABF, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h709A_D2AF, 32'h709A_D2AF, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h5FF7_9ABF, 32'h709A_D2AF, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h5FF7_9ABF, 32'h709A_D2AF, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h709A_D2AF, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'hE4F3_31CF, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'hE4F3_31CF, 32'hE4F3_31CF, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].instr);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_all, vecs[i].exp_valid);
    end

    // Spot checks of the literal field values for the first loaded word.
    drive(1'b0, 1'b1, 32'h5FF7_9ABF);
    @(posedge clk); #1;
    cmp("lit 25_21", 32'(bus.instr_25_21), 32'h1F);
    cmp("lit 20_16", 32'(bus.instr_20_16), 32'h17);
    cmp("lit 15_0",  32'(bus.instr_15_0),  32'h9ABF);
    cmp("lit 31_26", 32'(bus.instr_31_26), 32'h17);

    // No bypass: a new word with load_ir high must not show before the edge.
    drive(1'b0, 1'b1, 32'h0BAD_CAFE);
    #1;
    check_all("nobypass", 32'h5FF7_9ABF, 1'b1);
    @(posedge clk); #1;
    check_all("afterload", 32'h0BAD_CAFE, 1'b1);

    // Back-to-back loads reload every cycle.
    drive(1'b0, 1'b1, 32'h1111_2222);
    @(posedge clk); #1;
    check_all("b2b0", 32'h1111_2222, 1'b1);
    drive(1'b0, 1'b1, 32'h3333_4444);
    @(posedge clk); #1;
    check_all("b2b1", 32'h3333_4444, 1'b1);

    // Random sweep against the behavioural model.
    m_word  = 32'h3333_4444;
    m_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic        r, l;
      logic [31:0] w;
      r = ($urandom_range(0, 31) == 0);
      l = $urandom_range(0, 1) == 1;
      w = $urandom;
      drive(r, l, w);
      @(posedge clk); #1;
      if (r) begin
        m_word  = 32'h0;
        m_valid = 1'b0;
      end else if (l) begin
        m_word  = w;
        m_valid = 1'b1;
      end
      check_all($sformatf("rnd%0d", i), m_word, m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
